// File: rtl/aurora_frame_rx.sv
// Aurora RX frame decoder: splits the word stream into credit frames and data frames.
// Optional trailing per-frame XOR checksum is enabled by defining RX_CKSUM_EN.
module aurora_frame_rx #(
  parameter int LEN_W  = 16,
  parameter int SLOT_W = 18
) (
  input  logic              user_clk,
  input  logic              rst_in,
  input  logic              channel_rdy,
  input  logic [31:0]       rx_data,
  input  logic              rx_data_src_rdy,
  input  logic              fifo_full_i,
  output logic [31:0]       fifo_wr_dat_o,
  output logic              fifo_wr_o,
  output logic [SLOT_W-1:0] partner_empty_slots,
  output logic              partner_empty_slots_valid,
  output logic              frame_done_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

`ifdef RX_CKSUM_EN
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1, ST_CKSUM = 2'd2} state_t;
  logic [31:0] xor_acc;
`else
  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1} state_t;
`endif

  localparam logic [3:0] TYPE_CREDIT = 4'hC;
  localparam logic [3:0] TYPE_DATA   = 4'hD;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             accept;
  logic             err_event;
  logic [3:0]       hdr_type;
  logic [LEN_W-1:0] hdr_len;

  assign accept   = channel_rdy & rx_data_src_rdy;
  assign hdr_type = rx_data[31:28];
  assign hdr_len  = rx_data[LEN_W-1:0];

  // At most one error per accepted word; an abort cycle never counts.
  always_comb begin
    err_event = 1'b0;
    if (accept) begin
      case (state)
        ST_HDR: begin
          if (hdr_type == TYPE_DATA)
            err_event = (hdr_len == '0);
          else if (hdr_type != TYPE_CREDIT)
            err_event = 1'b1;
        end
        ST_DATA: err_event = fifo_full_i;
`ifdef RX_CKSUM_EN
        ST_CKSUM: err_event = (rx_data != xor_acc);
`endif
        default: err_event = 1'b0;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge rst_in) begin
    if (rst_in) begin
      state                     <= ST_HDR;
      remain                    <= '0;
      fifo_wr_o                 <= 1'b0;
      fifo_wr_dat_o             <= '0;
      partner_empty_slots       <= '0;
      partner_empty_slots_valid <= 1'b0;
      frame_done_o              <= 1'b0;
      err_o                     <= 1'b0;
      err_cnt_o                 <= '0;
`ifdef RX_CKSUM_EN
      xor_acc                   <= '0;
`endif
    end else begin
      fifo_wr_o    <= 1'b0;
      frame_done_o <= 1'b0;

      if (err_event) begin
        err_o <= 1'b1;
        if (err_cnt_o != 8'hFF)
          err_cnt_o <= err_cnt_o + 8'd1;
      end

      if (!channel_rdy) begin
        state                     <= ST_HDR;
        remain                    <= '0;
        partner_empty_slots_valid <= 1'b0;
`ifdef RX_CKSUM_EN
        xor_acc                   <= '0;
`endif
      end else if (rx_data_src_rdy) begin
        case (state)
          ST_HDR: begin
            if (hdr_type == TYPE_CREDIT) begin
              partner_empty_slots       <= rx_data[SLOT_W-1:0];
              partner_empty_slots_valid <= 1'b1;
            end else if (hdr_type == TYPE_DATA && hdr_len != '0) begin
              remain <= hdr_len;
              state  <= ST_DATA;
`ifdef RX_CKSUM_EN
              xor_acc <= '0;
`endif
            end
          end
          ST_DATA: begin
            // Dropped words still consume a count so framing stays aligned.
            if (!fifo_full_i) begin
              fifo_wr_o     <= 1'b1;
              fifo_wr_dat_o <= rx_data;
            end
            remain <= remain - LEN_W'(1);
`ifdef RX_CKSUM_EN
            xor_acc <= xor_acc ^ rx_data;
            if (remain == LEN_W'(1))
              state <= ST_CKSUM;
`else
            if (remain == LEN_W'(1)) begin
              state        <= ST_HDR;
              frame_done_o <= 1'b1;
            end
`endif
          end
`ifdef RX_CKSUM_EN
          ST_CKSUM: begin
            state        <= ST_HDR;
            frame_done_o <= 1'b1;
            xor_acc      <= '0;
          end
`endif
          default: state <= ST_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aurora_frame_rx.sv
// Directed vector bench for aurora_frame_rx; follows RX_CKSUM_EN when defined.
module tb_aurora_frame_rx;

  logic        user_clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        channel_rdy = 1'b1;
  logic [31:0] rx_data = '0;
  logic        rx_data_src_rdy = 1'b0;
  logic        fifo_full_i = 1'b0;
  logic [31:0] fifo_wr_dat_o;
  logic        fifo_wr_o;
  logic [17:0] partner_empty_slots;
  logic        partner_empty_slots_valid;
  logic        frame_done_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int tests = 0;
  int fails = 0;

  aurora_frame_rx #(.LEN_W(16), .SLOT_W(18)) dut (
    .user_clk                  (user_clk),
    .rst_in                    (rst_in),
    .channel_rdy               (channel_rdy),
    .rx_data                   (rx_data),
    .rx_data_src_rdy           (rx_data_src_rdy),
    .fifo_full_i               (fifo_full_i),
    .fifo_wr_dat_o             (fifo_wr_dat_o),
    .fifo_wr_o                 (fifo_wr_o),
    .partner_empty_slots       (partner_empty_slots),
    .partner_empty_slots_valid (partner_empty_slots_valid),
    .frame_done_o              (frame_done_o),
    .err_o                     (err_o),
    .err_cnt_o                 (err_cnt_o)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic        cr, v, f;
    logic [31:0] d;
    logic        wr;
    logic [31:0] dat;
    logic        done, valid;
    logic [17:0] slots;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cr, input logic v, input logic f, input logic [31:0] d,
                     input logic wr, input logic [31:0] dat, input logic done,
                     input logic valid, input logic [17:0] slots, input logic err,
                     input logic [7:0] cnt);
    vec_t t;
    t.cr = cr; t.v = v; t.f = f; t.d = d; t.wr = wr; t.dat = dat; t.done = done;
    t.valid = valid; t.slots = slots; t.err = err; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " fifo_wr_o"}, 32'(fifo_wr_o), 32'h0);
    check({tag, " fifo_wr_dat_o"}, fifo_wr_dat_o, 32'h0);
    check({tag, " slots"}, 32'(partner_empty_slots), 32'h0);
    check({tag, " slots_valid"}, 32'(partner_empty_slots_valid), 32'h0);
    check({tag, " frame_done_o"}, 32'(frame_done_o), 32'h0);
    check({tag, " err_o"}, 32'(err_o), 32'h0);
    check({tag, " err_cnt_o"}, 32'(err_cnt_o), 32'h0);
  endtask

  initial begin
    // cr v f  data          wr dat           done vld slots      err cnt
    add(1, 1, 0, 32'hC000_1234, 0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    add(1, 1, 0, 32'hD000_0003, 0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    add(1, 1, 0, 32'h0000_0011, 1, 32'h11,       0, 1, 18'h01234, 0, 8'd0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    add(1, 1, 0, 32'h0000_0022, 1, 32'h22,       0, 1, 18'h01234, 0, 8'd0);
`ifdef RX_CKSUM_EN
    add(1, 1, 0, 32'h0000_0033, 1, 32'h33,       0, 1, 18'h01234, 0, 8'd0);
    add(1, 1, 0, 32'h0000_0000, 0, 32'h0,        1, 1, 18'h01234, 0, 8'd0);
`else
    add(1, 1, 0, 32'h0000_0033, 1, 32'h33,       1, 1, 18'h01234, 0, 8'd0);
`endif
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 1, 18'h01234, 0, 8'd0);
    // zero-length header, then a bad type
    add(1, 1, 0, 32'hD000_0000, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd1);
    add(1, 1, 0, 32'h5000_0000, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd2);
    // length-4 frame, FIFO full on the 2nd word
    add(1, 1, 0, 32'hD000_0004, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd2);
    add(1, 1, 0, 32'h0000_0001, 1, 32'h1,        0, 1, 18'h01234, 1, 8'd2);
    add(1, 1, 1, 32'h0000_0002, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd3);
    add(1, 1, 0, 32'h0000_0004, 1, 32'h4,        0, 1, 18'h01234, 1, 8'd3);
`ifdef RX_CKSUM_EN
    add(1, 1, 0, 32'h0000_0008, 1, 32'h8,        0, 1, 18'h01234, 1, 8'd3);
    add(1, 1, 0, 32'h0000_000F, 0, 32'h0,        1, 1, 18'h01234, 1, 8'd3);
`else
    add(1, 1, 0, 32'h0000_0008, 1, 32'h8,        1, 1, 18'h01234, 1, 8'd3);
`endif
    // back-to-back header right after the last word
    add(1, 1, 0, 32'hD000_0001, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd3);
`ifdef RX_CKSUM_EN
    add(1, 1, 0, 32'h0000_BEEF, 1, 32'hBEEF,     0, 1, 18'h01234, 1, 8'd3);
    add(1, 1, 0, 32'h0000_BEEF, 0, 32'h0,        1, 1, 18'h01234, 1, 8'd3);
`else
    add(1, 1, 0, 32'h0000_BEEF, 1, 32'hBEEF,     1, 1, 18'h01234, 1, 8'd3);
`endif
    // abort after 2 of 5 words; the word in the abort cycle is ignored
    add(1, 1, 0, 32'hD000_0005, 0, 32'h0,        0, 1, 18'h01234, 1, 8'd3);
    add(1, 1, 0, 32'h0000_0101, 1, 32'h101,      0, 1, 18'h01234, 1, 8'd3);
    add(1, 1, 0, 32'h0000_0102, 1, 32'h102,      0, 1, 18'h01234, 1, 8'd3);
    add(0, 1, 0, 32'h0000_0103, 0, 32'h0,        0, 0, 18'h01234, 1, 8'd3);
    add(0, 0, 0, 32'h0,         0, 32'h0,        0, 0, 18'h01234, 1, 8'd3);
    // credit with bits above SLOT_W set, then a normal one
    add(1, 1, 0, 32'hC0FF_FFFF, 0, 32'h0,        0, 1, 18'h3FFFF, 1, 8'd3);
    add(1, 1, 0, 32'hC000_0007, 0, 32'h0,        0, 1, 18'h00007, 1, 8'd3);
    // length-1 frame whose payload looks like a credit word
    add(1, 1, 0, 32'hD000_0001, 0, 32'h0,        0, 1, 18'h00007, 1, 8'd3);
`ifdef RX_CKSUM_EN
    add(1, 1, 0, 32'hC000_0099, 1, 32'hC000_0099, 0, 1, 18'h00007, 1, 8'd3);
    add(1, 1, 0, 32'hC000_0099, 0, 32'h0,        1, 1, 18'h00007, 1, 8'd3);
`else
    add(1, 1, 0, 32'hC000_0099, 1, 32'hC000_0099, 1, 1, 18'h00007, 1, 8'd3);
`endif

    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    rst_in = 1'b0;
    check_all_zero("reset");

    foreach (vecs[i]) begin
      channel_rdy     = vecs[i].cr;
      rx_data_src_rdy = vecs[i].v;
      fifo_full_i     = vecs[i].f;
      rx_data         = vecs[i].d;
      @(negedge user_clk);
      $display("[TB] vec %0d data=%h wr=%0d dat=%h done=%0d vld=%0d slots=%h err=%0d cnt=%0d",
               i, vecs[i].d, fifo_wr_o, fifo_wr_dat_o, frame_done_o,
               partner_empty_slots_valid, partner_empty_slots, err_o, err_cnt_o);
      check($sformatf("v%0d fifo_wr_o", i), 32'(fifo_wr_o), 32'(vecs[i].wr));
      if (vecs[i].wr)
        check($sformatf("v%0d fifo_wr_dat_o", i), fifo_wr_dat_o, vecs[i].dat);
      check($sformatf("v%0d frame_done_o", i), 32'(frame_done_o), 32'(vecs[i].done));
      check($sformatf("v%0d slots_valid", i), 32'(partner_empty_slots_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d slots", i), 32'(partner_empty_slots), 32'(vecs[i].slots));
      check($sformatf("v%0d err_o", i), 32'(err_o), 32'(vecs[i].err));
      check($sformatf("v%0d err_cnt_o", i), 32'(err_cnt_o), 32'(vecs[i].cnt));
    end

    // 300 bad-type words: count climbs from 3 and saturates at 8'hFF
    channel_rdy = 1'b1; fifo_full_i = 1'b0;
    rx_data_src_rdy = 1'b1; rx_data = 32'h5000_0000;
    for (int k = 0; k < 300; k++) begin
      @(negedge user_clk);
      if (k == 251)
        check("sat cnt at 252", 32'(err_cnt_o), 32'hFF);
      if (k == 250)
        check("sat cnt at 251", 32'(err_cnt_o), 32'hFE);
    end
    $display("[TB] bad-word burst err_cnt_o=%h err_o=%0d", err_cnt_o, err_o);
    check("sat cnt final", 32'(err_cnt_o), 32'hFF);
    check("sat slots_valid held", 32'(partner_empty_slots_valid), 32'h1);
    check("sat slots held", 32'(partner_empty_slots), 32'h7);

    // asynchronous reset mid-stream, between clock edges
    #2 rst_in = 1'b1;
    #1;
    $display("[TB] async reset err_cnt_o=%h err_o=%0d vld=%0d", err_cnt_o, err_o,
             partner_empty_slots_valid);
    check_all_zero("async reset");
    rx_data_src_rdy = 1'b0;
    @(negedge user_clk);
    rst_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aurora_frame_rx.md
# aurora_frame_rx

Receive-side frame decoder for the Aurora link controller. It parses the 32-bit word stream from the Aurora RX user interface into two kinds of frame: credit frames, which carry the partner's empty-slot count to our transmitter, and data frames, whose payload is written into the local receive FIFO. It is the decode counterpart of the credit/data framing produced by the link transmitter, and sits between the Aurora core RX port and the hold FIFO.

## Interface
Parameters:
- LEN_W, 16, width of the data-header length field (header bits [LEN_W-1:0]); maximum payload is 2^LEN_W-1 words.
- SLOT_W, 18, width of the credit field and of partner_empty_slots.

Ports:
- user_clk  in  1  Aurora user clock; all logic is on the rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- channel_rdy  in  1  Aurora channel up. When low, the block performs a synchronous abort.
- rx_data  in  32  Aurora RX word.
- rx_data_src_rdy  in  1  rx_data valid. There is no backpressure.
- fifo_full_i  in  1  almost-full flag of the receive FIFO.
- fifo_wr_dat_o  out  32  payload word to the FIFO.
- fifo_wr_o  out  1  FIFO write strobe, one cycle per word.
- partner_empty_slots  out  SLOT_W  last received credit value.
- partner_empty_slots_valid  out  1  level; high once a credit has been received since reset or channel-up.
- frame_done_o  out  1  one-cycle pulse when a data frame completes.
- err_o  out  1  sticky error flag; cleared only by rst_in.
- err_cnt_o  out  8  saturating error count.

## Operation
- Only words with rx_data_src_rdy=1 are accepted. Idle cycles do not advance the state machine.
- Header word decode, using bits [31:28]:
  - 4'hC: credit word. Load partner_empty_slots from [SLOT_W-1:0] and set partner_empty_slots_valid.
  - 4'hD: data header. Load the remaining-word counter from [LEN_W-1:0].
  - Any other type: error; the word is discarded.
- States:
  - HDR (reset state):
    - Credit word: stay in HDR.
    - Data header with len≥1: go to DATA.
    - Data header with len=0: error, stay in HDR.
    - Bad type: error, stay in HDR.
  - DATA: each accepted word is written to the FIFO and decrements the counter.
    - On the last word (counter=1), go to CKSUM if RX_CKSUM_EN is defined, otherwise go to HDR and pulse frame_done_o.
  - CKSUM: the accepted word is compared with the running XOR of the frame's payload.
    - Mismatch: error.
    - Always: go to HDR and pulse frame_done_o.
- Credit words are recognised only in HDR. Any word received in DATA is payload, whatever its top bits.
- Overflow: if fifo_full_i=1 when a payload word is accepted, the word is dropped (fifo_wr_o stays 0) and an error is raised. The counter still decrements, so framing stays aligned.
- Error event: set err_o and increment err_cnt_o, saturating at 8'hFF. At most one error is counted per accepted word.
- channel_rdy=0 (synchronous abort):
  - state goes to HDR, the counter and XOR clear, and partner_empty_slots_valid clears;
  - partner_empty_slots, err_o and err_cnt_o hold their values;
  - a partial frame is abandoned with no frame_done_o pulse;
  - words already written to the FIFO are not recalled.
- Reset values (rst_in): state HDR; fifo_wr_o=0; fifo_wr_dat_o=0; partner_empty_slots=0; partner_empty_slots_valid=0; frame_done_o=0; err_o=0; err_cnt_o=0.

## Timing
- All outputs are registered.
- Accepted payload word at edge N: fifo_wr_o=1 with fifo_wr_dat_o equal to that word in the cycle after edge N. Latency is 1 cycle.
- A credit word updates partner_empty_slots and partner_empty_slots_valid 1 cycle after acceptance.
- frame_done_o pulses 1 cycle after the last payload word (or the checksum word, when enabled) is accepted.
- Back-to-back frames are accepted with no gap: the header of the next frame may arrive in the cycle immediately after the last word.
- fifo_full_i is sampled in the same cycle as rx_data_src_rdy.
- If channel_rdy=0 and rx_data_src_rdy=1 in the same cycle, the abort wins and the word is ignored.
- Error detection and err_cnt_o update 1 cycle after the offending word.

## Configuration
- RX_CKSUM_EN defined:
  - every data frame carries one trailing checksum word, equal to the XOR of all its payload words;
  - the CKSUM state and the 32-bit XOR register are present;
  - a mismatch raises an error;
  - the checksum word is never written to the FIFO.
- RX_CKSUM_EN undefined: no CKSUM state and no XOR logic; the frame ends at its last payload word.

## Test plan
- Credit word 32'hC000_1234 → partner_empty_slots=18'h01234 and partner_empty_slots_valid=1 one cycle later; no FIFO write.
- Header 32'hD000_0003, then 32'h11, 32'h22, 32'h33 with idle cycles interleaved → exactly 3 writes in order, then a single frame_done_o pulse. With RX_CKSUM_EN, append 32'h00 (11^22^33=00) → err_o stays 0.
- Header 32'hD000_0000, then 32'h5000_0000 → err_cnt_o=2, err_o=1, state HDR, no writes.
- Frame of length 4 with fifo_full_i=1 during the 2nd word → 3 writes, err_cnt_o=1, frame_done_o still pulses, and the next header is decoded correctly.
- channel_rdy dropped after 2 of 5 payload words, then raised and a credit word plus a length-1 frame sent → valid clears then sets again, no frame_done_o for the aborted frame, and the new frame is written.
- 300 bad-type words → err_cnt_o saturates at 8'hFF; asserting rst_in mid-stream clears all outputs immediately.
